// File: rtl/axi_lite_xbar.sv
// Single-master, two-slave AXI-Lite crossbar with one transaction in flight; address misses get DECERR.
// Latency: read accept -> slave AR -> R passthrough (3 cycles minimum to m_rvalid_o with a zero-wait slave).
// Backpressure: master ready only in IDLE after the post-reset init cycle; slave/master responses are passed straight through.
//
// Ports:
//   clk_i, rst_i            : clock, async active-low reset
//   m_*                     : AXI-Lite slave port facing the single master
//   s0_* (SRAM), s1_* (DEV) : AXI-Lite master ports facing the two slaves
module axi_lite_xbar #(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 32,
  parameter int              STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [31:0]     SRAM_BASE  = 32'h8000_0000,
  parameter logic [31:0]     SRAM_SIZE  = 32'h0800_0000,
  parameter logic [31:0]     DEV_BASE   = 32'ha000_0000,
  parameter logic [31:0]     DEV_SIZE   = 32'h0001_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // master side
  input  logic [ADDR_WIDTH-1:0] m_araddr_i,
  input  logic [ADDR_WIDTH-1:0] m_awaddr_i,
  input  logic [DATA_WIDTH-1:0] m_wdata_i,
  input  logic [STRB_WIDTH-1:0] m_wstrb_i,
  input  logic                  m_arvalid_i,
  input  logic                  m_awvalid_i,
  input  logic                  m_wvalid_i,
  input  logic                  m_rready_i,
  input  logic                  m_bready_i,
  output logic                  m_arready_o,
  output logic                  m_awready_o,
  output logic                  m_wready_o,
  output logic                  m_rvalid_o,
  output logic                  m_bvalid_o,
  output logic [DATA_WIDTH-1:0] m_rdata_o,
  output logic [1:0]            m_rresp_o,
  output logic [1:0]            m_bresp_o,
  // slave 0 (SRAM)
  output logic [ADDR_WIDTH-1:0] s0_araddr_o,
  output logic [ADDR_WIDTH-1:0] s0_awaddr_o,
  output logic [DATA_WIDTH-1:0] s0_wdata_o,
  output logic [STRB_WIDTH-1:0] s0_wstrb_o,
  output logic                  s0_arvalid_o,
  output logic                  s0_awvalid_o,
  output logic                  s0_wvalid_o,
  output logic                  s0_rready_o,
  output logic                  s0_bready_o,
  input  logic                  s0_arready_i,
  input  logic                  s0_awready_i,
  input  logic                  s0_wready_i,
  input  logic                  s0_rvalid_i,
  input  logic                  s0_bvalid_i,
  input  logic [DATA_WIDTH-1:0] s0_rdata_i,
  input  logic [1:0]            s0_rresp_i,
  input  logic [1:0]            s0_bresp_i,
  // slave 1 (DEV)
  output logic [ADDR_WIDTH-1:0] s1_araddr_o,
  output logic [ADDR_WIDTH-1:0] s1_awaddr_o,
  output logic [DATA_WIDTH-1:0] s1_wdata_o,
  output logic [STRB_WIDTH-1:0] s1_wstrb_o,
  output logic                  s1_arvalid_o,
  output logic                  s1_awvalid_o,
  output logic                  s1_wvalid_o,
  output logic                  s1_rready_o,
  output logic                  s1_bready_o,
  input  logic                  s1_arready_i,
  input  logic                  s1_awready_i,
  input  logic                  s1_wready_i,
  input  logic                  s1_rvalid_i,
  input  logic                  s1_bvalid_i,
  input  logic [DATA_WIDTH-1:0] s1_rdata_i,
  input  logic [1:0]            s1_rresp_i,
  input  logic [1:0]            s1_bresp_i
);

  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AW, ST_B, ST_ERR_R, ST_ERR_B} state_t;

  // Window bounds carry one extra bit so BASE+SIZE at the top of the map cannot wrap.
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] L_S0_LO = AW1'(SRAM_BASE);
  localparam logic [ADDR_WIDTH:0] L_S0_HI = AW1'(SRAM_BASE) + AW1'(SRAM_SIZE);
  localparam logic [ADDR_WIDTH:0] L_S1_LO = AW1'(DEV_BASE);
  localparam logic [ADDR_WIDTH:0] L_S1_HI = AW1'(DEV_BASE) + AW1'(DEV_SIZE);

  function automatic logic in_win(input logic [ADDR_WIDTH-1:0] a,
                                  input logic [ADDR_WIDTH:0]   lo,
                                  input logic [ADDR_WIDTH:0]   hi);
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  state_t                r_state, w_state_nxt;
  logic                  r_init;
  logic                  r_sel;       // 0: s0, 1: s1
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_aw_done, r_w_done;

  logic w_rd_hit0, w_rd_hit1, w_wr_hit0, w_wr_hit1;
  logic w_lat_rd, w_lat_wr;
  logic w_arvalid, w_awvalid, w_wvalid, w_rready, w_bready;

  assign w_rd_hit0 = in_win(m_araddr_i, L_S0_LO, L_S0_HI);
  assign w_rd_hit1 = in_win(m_araddr_i, L_S1_LO, L_S1_HI);
  assign w_wr_hit0 = in_win(m_awaddr_i, L_S0_LO, L_S0_HI);
  assign w_wr_hit1 = in_win(m_awaddr_i, L_S1_LO, L_S1_HI);

  // Inputs from whichever slave is selected.
  logic                  w_s_arready, w_s_awready, w_s_wready, w_s_rvalid, w_s_bvalid;
  logic [DATA_WIDTH-1:0] w_s_rdata;
  logic [1:0]            w_s_rresp, w_s_bresp;

  assign w_s_arready = r_sel ? s1_arready_i : s0_arready_i;
  assign w_s_awready = r_sel ? s1_awready_i : s0_awready_i;
  assign w_s_wready  = r_sel ? s1_wready_i  : s0_wready_i;
  assign w_s_rvalid  = r_sel ? s1_rvalid_i  : s0_rvalid_i;
  assign w_s_bvalid  = r_sel ? s1_bvalid_i  : s0_bvalid_i;
  assign w_s_rdata   = r_sel ? s1_rdata_i   : s0_rdata_i;
  assign w_s_rresp   = r_sel ? s1_rresp_i   : s0_rresp_i;
  assign w_s_bresp   = r_sel ? s1_bresp_i   : s0_bresp_i;

  always_comb begin
    w_state_nxt = r_state;
    w_lat_rd    = 1'b0;
    w_lat_wr    = 1'b0;
    w_arvalid   = 1'b0;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_rready    = 1'b0;
    w_bready    = 1'b0;
    m_arready_o = 1'b0;
    m_awready_o = 1'b0;
    m_wready_o  = 1'b0;
    m_rvalid_o  = 1'b0;
    m_rdata_o   = '0;
    m_rresp_o   = 2'b00;
    m_bvalid_o  = 1'b0;
    m_bresp_o   = 2'b00;
    case (r_state)
      ST_IDLE: begin
        m_arready_o = r_init;
        if (r_init && m_arvalid_i) begin
          w_lat_rd    = 1'b1;
          w_state_nxt = (w_rd_hit0 || w_rd_hit1) ? ST_AR : ST_ERR_R;
        end else if (r_init && m_awvalid_i && m_wvalid_i) begin
          // AW and W are only taken together; a lone AW or W is left waiting.
          m_awready_o = 1'b1;
          m_wready_o  = 1'b1;
          w_lat_wr    = 1'b1;
          w_state_nxt = (w_wr_hit0 || w_wr_hit1) ? ST_AW : ST_ERR_B;
        end
      end
      ST_AR: begin
        w_arvalid = 1'b1;
        if (w_s_arready) w_state_nxt = ST_R;
      end
      ST_R: begin
        m_rvalid_o = w_s_rvalid;
        if (w_s_rvalid) begin
          m_rdata_o = w_s_rdata;
          m_rresp_o = w_s_rresp;
        end
        w_rready = m_rready_i;
        if (w_s_rvalid && m_rready_i) w_state_nxt = ST_IDLE;
      end
      ST_AW: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        if ((r_aw_done || w_s_awready) && (r_w_done || w_s_wready)) w_state_nxt = ST_B;
      end
      ST_B: begin
        m_bvalid_o = w_s_bvalid;
        if (w_s_bvalid) m_bresp_o = w_s_bresp;
        w_bready = m_bready_i;
        if (w_s_bvalid && m_bready_i) w_state_nxt = ST_IDLE;
      end
      ST_ERR_R: begin
        m_rvalid_o = 1'b1;
        m_rresp_o  = 2'b11;
        if (m_rready_i) w_state_nxt = ST_IDLE;
      end
      ST_ERR_B: begin
        m_bvalid_o = 1'b1;
        m_bresp_o  = 2'b11;
        if (m_bready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_init    <= 1'b0;
      r_sel     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_init  <= 1'b1;
      if (w_lat_rd) begin
        r_addr <= m_araddr_i;
        r_sel  <= !w_rd_hit0 && w_rd_hit1;
      end else if (w_lat_wr) begin
        r_addr  <= m_awaddr_i;
        r_wdata <= m_wdata_i;
        r_wstrb <= m_wstrb_i;
        r_sel   <= !w_wr_hit0 && w_wr_hit1;
      end
      if (r_state == ST_AW) begin
        if (w_state_nxt == ST_B) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end else begin
          if (w_awvalid && w_s_awready) r_aw_done <= 1'b1;
          if (w_wvalid && w_s_wready)   r_w_done  <= 1'b1;
        end
      end
    end
  end

  assign s0_arvalid_o = w_arvalid & ~r_sel;
  assign s0_awvalid_o = w_awvalid & ~r_sel;
  assign s0_wvalid_o  = w_wvalid  & ~r_sel;
  assign s0_rready_o  = w_rready  & ~r_sel;
  assign s0_bready_o  = w_bready  & ~r_sel;
  assign s1_arvalid_o = w_arvalid &  r_sel;
  assign s1_awvalid_o = w_awvalid &  r_sel;
  assign s1_wvalid_o  = w_wvalid  &  r_sel;
  assign s1_rready_o  = w_rready  &  r_sel;
  assign s1_bready_o  = w_bready  &  r_sel;

  assign s0_araddr_o = r_addr;
  assign s0_awaddr_o = r_addr;
  assign s0_wdata_o  = r_wdata;
  assign s0_wstrb_o  = r_wstrb;
  assign s1_araddr_o = r_addr;
  assign s1_awaddr_o = r_addr;
  assign s1_wdata_o  = r_wdata;
  assign s1_wstrb_o  = r_wstrb;

endmodule

// File: tb/tb_axi_lite_xbar.sv
module tb_axi_lite_xbar;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] m_araddr_i = '0, m_awaddr_i = '0, m_wdata_i = '0;
  logic [3:0]  m_wstrb_i = '0;
  logic m_arvalid_i = 0, m_awvalid_i = 0, m_wvalid_i = 0, m_rready_i = 0, m_bready_i = 0;
  logic m_arready_o, m_awready_o, m_wready_o, m_rvalid_o, m_bvalid_o;
  logic [31:0] m_rdata_o;
  logic [1:0]  m_rresp_o, m_bresp_o;

  logic [31:0] s0_araddr_o, s0_awaddr_o, s0_wdata_o, s1_araddr_o, s1_awaddr_o, s1_wdata_o;
  logic [3:0]  s0_wstrb_o, s1_wstrb_o;
  logic s0_arvalid_o, s0_awvalid_o, s0_wvalid_o, s0_rready_o, s0_bready_o;
  logic s1_arvalid_o, s1_awvalid_o, s1_wvalid_o, s1_rready_o, s1_bready_o;
  logic s0_arready_i = 0, s0_awready_i = 0, s0_wready_i = 0, s0_rvalid_i = 0, s0_bvalid_i = 0;
  logic s1_arready_i = 0, s1_awready_i = 0, s1_wready_i = 0, s1_rvalid_i = 0, s1_bvalid_i = 0;
  logic [31:0] s0_rdata_i = '0, s1_rdata_i = '0;
  logic [1:0]  s0_rresp_i = '0, s0_bresp_i = '0, s1_rresp_i = '0, s1_bresp_i = '0;

  always #5 clk_i = ~clk_i;

  axi_lite_xbar dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_araddr_i(m_araddr_i), .m_awaddr_i(m_awaddr_i), .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
    .m_arvalid_i(m_arvalid_i), .m_awvalid_i(m_awvalid_i), .m_wvalid_i(m_wvalid_i),
    .m_rready_i(m_rready_i), .m_bready_i(m_bready_i),
    .m_arready_o(m_arready_o), .m_awready_o(m_awready_o), .m_wready_o(m_wready_o),
    .m_rvalid_o(m_rvalid_o), .m_bvalid_o(m_bvalid_o), .m_rdata_o(m_rdata_o),
    .m_rresp_o(m_rresp_o), .m_bresp_o(m_bresp_o),
    .s0_araddr_o(s0_araddr_o), .s0_awaddr_o(s0_awaddr_o), .s0_wdata_o(s0_wdata_o), .s0_wstrb_o(s0_wstrb_o),
    .s0_arvalid_o(s0_arvalid_o), .s0_awvalid_o(s0_awvalid_o), .s0_wvalid_o(s0_wvalid_o),
    .s0_rready_o(s0_rready_o), .s0_bready_o(s0_bready_o),
    .s0_arready_i(s0_arready_i), .s0_awready_i(s0_awready_i), .s0_wready_i(s0_wready_i),
    .s0_rvalid_i(s0_rvalid_i), .s0_bvalid_i(s0_bvalid_i), .s0_rdata_i(s0_rdata_i),
    .s0_rresp_i(s0_rresp_i), .s0_bresp_i(s0_bresp_i),
    .s1_araddr_o(s1_araddr_o), .s1_awaddr_o(s1_awaddr_o), .s1_wdata_o(s1_wdata_o), .s1_wstrb_o(s1_wstrb_o),
    .s1_arvalid_o(s1_arvalid_o), .s1_awvalid_o(s1_awvalid_o), .s1_wvalid_o(s1_wvalid_o),
    .s1_rready_o(s1_rready_o), .s1_bready_o(s1_bready_o),
    .s1_arready_i(s1_arready_i), .s1_awready_i(s1_awready_i), .s1_wready_i(s1_wready_i),
    .s1_rvalid_i(s1_rvalid_i), .s1_bvalid_i(s1_bvalid_i), .s1_rdata_i(s1_rdata_i),
    .s1_rresp_i(s1_rresp_i), .s1_bresp_i(s1_bresp_i)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    #1;
    n_tests++; if (m_arready_o !== 1'b0) begin n_fail++; $display("FAIL rst_arready: got %b want 0", m_arready_o); end
    n_tests++; if (m_rvalid_o !== 1'b0 || m_bvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valids: got r=%b b=%b want 0", m_rvalid_o, m_bvalid_o); end
    n_tests++; if (s0_araddr_o !== 32'h0 || s0_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_s0: got addr=%h vld=%b want 0", s0_araddr_o, s0_arvalid_o); end
    @(negedge clk_i); rst_i = 1'b1; #1;
    n_tests++; if (m_arready_o !== 1'b0) begin n_fail++; $display("FAIL rel_arready_early: got %b want 0", m_arready_o); end
    @(negedge clk_i); #1;
    n_tests++; if (m_arready_o !== 1'b1) begin n_fail++; $display("FAIL rel_arready_late: got %b want 1", m_arready_o); end
  endtask

  task automatic test_read_s0();
    s0_arready_i = 1; s0_rvalid_i = 1; s0_rdata_i = 32'hDEADBEEF; s0_rresp_i = 2'b00; m_rready_i = 1;
    @(negedge clk_i); m_arvalid_i = 1; m_araddr_i = 32'h8000_0010; #1;
    n_tests++; if (m_arready_o !== 1'b1) begin n_fail++; $display("FAIL rd_accept: got %b want 1", m_arready_o); end
    @(negedge clk_i); m_arvalid_i = 0; #1;
    n_tests++; if (s0_arvalid_o !== 1'b1 || s0_araddr_o !== 32'h8000_0010) begin n_fail++; $display("FAIL rd_ar: got vld=%b addr=%h want 1/80000010", s0_arvalid_o, s0_araddr_o); end
    n_tests++; if (s1_arvalid_o !== 1'b0 || m_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rd_ar_quiet: got s1ar=%b rvld=%b want 0/0", s1_arvalid_o, m_rvalid_o); end
    @(negedge clk_i); #1;
    n_tests++; if (m_rvalid_o !== 1'b1 || m_rdata_o !== 32'hDEADBEEF || m_rresp_o !== 2'b00) begin n_fail++; $display("FAIL rd_data: got v=%b d=%h r=%b want 1/deadbeef/00", m_rvalid_o, m_rdata_o, m_rresp_o); end
    n_tests++; if (s0_rready_o !== 1'b1 || s1_rready_o !== 1'b0 || s0_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rd_rready: got s0=%b s1=%b ar=%b want 1/0/0", s0_rready_o, s1_rready_o, s0_arvalid_o); end
    @(negedge clk_i); #1;
    n_tests++; if (m_rvalid_o !== 1'b0 || m_rdata_o !== 32'h0 || m_arready_o !== 1'b1) begin n_fail++; $display("FAIL rd_done: got v=%b d=%h ar=%b want 0/0/1", m_rvalid_o, m_rdata_o, m_arready_o); end
  endtask

  task automatic test_write_s1_delayed();
    s1_awready_i = 0; s1_wready_i = 1; s1_bvalid_i = 1; s1_bresp_i = 2'b00; m_bready_i = 1;
    @(negedge clk_i); m_awvalid_i = 1; m_wvalid_i = 1; m_awaddr_i = 32'hA000_03F8; m_wdata_i = 32'h41; m_wstrb_i = 4'b0001; #1;
    n_tests++; if (m_awready_o !== 1'b1 || m_wready_o !== 1'b1) begin n_fail++; $display("FAIL wr_accept: got aw=%b w=%b want 1/1", m_awready_o, m_wready_o); end
    @(negedge clk_i); m_awvalid_i = 0; m_wvalid_i = 0; #1;
    n_tests++; if (s1_awvalid_o !== 1'b1 || s1_wvalid_o !== 1'b1 || s0_awvalid_o !== 1'b0) begin n_fail++; $display("FAIL wr_aw1: got aw=%b w=%b s0aw=%b want 1/1/0", s1_awvalid_o, s1_wvalid_o, s0_awvalid_o); end
    n_tests++; if (s1_awaddr_o !== 32'hA000_03F8 || s1_wdata_o !== 32'h41 || s1_wstrb_o !== 4'b0001) begin n_fail++; $display("FAIL wr_payload: got a=%h d=%h s=%b want a00003f8/41/0001", s1_awaddr_o, s1_wdata_o, s1_wstrb_o); end
    @(negedge clk_i); #1;
    n_tests++; if (s1_wvalid_o !== 1'b0 || s1_awvalid_o !== 1'b1) begin n_fail++; $display("FAIL wr_aw2: got w=%b aw=%b want 0/1", s1_wvalid_o, s1_awvalid_o); end
    @(negedge clk_i); s1_awready_i = 1; #1;
    n_tests++; if (m_bvalid_o !== 1'b0 || s1_bready_o !== 1'b0) begin n_fail++; $display("FAIL wr_early_b: got bv=%b br=%b want 0/0", m_bvalid_o, s1_bready_o); end
    @(negedge clk_i); s1_awready_i = 0; #1;
    n_tests++; if (m_bvalid_o !== 1'b1 || m_bresp_o !== 2'b00 || s1_bready_o !== 1'b1 || s1_awvalid_o !== 1'b0) begin n_fail++; $display("FAIL wr_b: got bv=%b br=%b brdy=%b aw=%b want 1/00/1/0", m_bvalid_o, m_bresp_o, s1_bready_o, s1_awvalid_o); end
    @(negedge clk_i); #1;
    n_tests++; if (m_bvalid_o !== 1'b0) begin n_fail++; $display("FAIL wr_done: got %b want 0", m_bvalid_o); end
  endtask

  task automatic test_decerr_read();
    m_rready_i = 1;
    @(negedge clk_i); m_arvalid_i = 1; m_araddr_i = 32'h0000_1000; #1;
    n_tests++; if (m_arready_o !== 1'b1) begin n_fail++; $display("FAIL de_accept: got %b want 1", m_arready_o); end
    @(negedge clk_i); m_arvalid_i = 0; #1;
    n_tests++; if (m_rvalid_o !== 1'b1 || m_rresp_o !== 2'b11 || m_rdata_o !== 32'h0) begin n_fail++; $display("FAIL de_resp: got v=%b r=%b d=%h want 1/11/0", m_rvalid_o, m_rresp_o, m_rdata_o); end
    n_tests++; if (s0_arvalid_o !== 1'b0 || s1_arvalid_o !== 1'b0 || s0_rready_o !== 1'b0) begin n_fail++; $display("FAIL de_slaves: got s0=%b s1=%b rr=%b want 0/0/0", s0_arvalid_o, s1_arvalid_o, s0_rready_o); end
    @(negedge clk_i); #1;
    n_tests++; if (m_rvalid_o !== 1'b0 || m_rresp_o !== 2'b00) begin n_fail++; $display("FAIL de_done: got v=%b r=%b want 0/00", m_rvalid_o, m_rresp_o); end
  endtask

  task automatic test_rd_wr_priority();
    s1_awready_i = 1; s1_wready_i = 1; s1_bvalid_i = 1; s1_bresp_i = 2'b10; m_bready_i = 1; m_rready_i = 1;
    @(negedge clk_i);
    m_arvalid_i = 1; m_araddr_i = 32'h8000_0000;
    m_awvalid_i = 1; m_wvalid_i = 1; m_awaddr_i = 32'hA000_0000; m_wdata_i = 32'h1234_5678; m_wstrb_i = 4'hF;
    #1;
    n_tests++; if (m_arready_o !== 1'b1 || m_awready_o !== 1'b0 || m_wready_o !== 1'b0) begin n_fail++; $display("FAIL pri_accept: got ar=%b aw=%b w=%b want 1/0/0", m_arready_o, m_awready_o, m_wready_o); end
    @(negedge clk_i); m_arvalid_i = 0; #1;
    n_tests++; if (s0_arvalid_o !== 1'b1 || s0_araddr_o !== 32'h8000_0000 || m_awready_o !== 1'b0) begin n_fail++; $display("FAIL pri_ar: got vld=%b addr=%h awr=%b want 1/80000000/0", s0_arvalid_o, s0_araddr_o, m_awready_o); end
    @(negedge clk_i); #1;
    n_tests++; if (m_rvalid_o !== 1'b1 || m_rdata_o !== 32'hDEADBEEF || m_awready_o !== 1'b0) begin n_fail++; $display("FAIL pri_r: got v=%b d=%h awr=%b want 1/deadbeef/0", m_rvalid_o, m_rdata_o, m_awready_o); end
    @(negedge clk_i); #1;
    n_tests++; if (m_awready_o !== 1'b1 || m_wready_o !== 1'b1 || m_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL pri_wr_accept: got aw=%b w=%b rv=%b want 1/1/0", m_awready_o, m_wready_o, m_rvalid_o); end
    @(negedge clk_i); m_awvalid_i = 0; m_wvalid_i = 0; #1;
    n_tests++; if (s1_awvalid_o !== 1'b1 || s1_awaddr_o !== 32'hA000_0000 || s1_wdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL pri_aw: got vld=%b a=%h d=%h want 1/a0000000/12345678", s1_awvalid_o, s1_awaddr_o, s1_wdata_o); end
    @(negedge clk_i); #1;
    n_tests++; if (m_bvalid_o !== 1'b1 || m_bresp_o !== 2'b10 || s1_awvalid_o !== 1'b0 || s1_wvalid_o !== 1'b0) begin n_fail++; $display("FAIL pri_b: got bv=%b br=%b aw=%b w=%b want 1/10/0/0", m_bvalid_o, m_bresp_o, s1_awvalid_o, s1_wvalid_o); end
    @(negedge clk_i); #1;
    n_tests++; if (m_bvalid_o !== 1'b0 || m_bresp_o !== 2'b00) begin n_fail++; $display("FAIL pri_done: got bv=%b br=%b want 0/00", m_bvalid_o, m_bresp_o); end
    s1_awready_i = 0; s1_wready_i = 0; s1_bvalid_i = 0; s1_bresp_i = 2'b00;
  endtask

  task automatic test_boundary();
    m_rready_i = 1;
    @(negedge clk_i); m_arvalid_i = 1; m_araddr_i = 32'h87FF_FFFC; #1;
    @(negedge clk_i); m_arvalid_i = 0; #1;
    n_tests++; if (s0_arvalid_o !== 1'b1 || s0_araddr_o !== 32'h87FF_FFFC || m_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL bnd_last: got vld=%b addr=%h rv=%b want 1/87fffffc/0", s0_arvalid_o, s0_araddr_o, m_rvalid_o); end
    @(negedge clk_i); #1;
    n_tests++; if (m_rvalid_o !== 1'b1 || m_rresp_o !== 2'b00) begin n_fail++; $display("FAIL bnd_last_r: got v=%b r=%b want 1/00", m_rvalid_o, m_rresp_o); end
    @(negedge clk_i); m_arvalid_i = 1; m_araddr_i = 32'h8800_0000; #1;
    @(negedge clk_i); m_arvalid_i = 0; #1;
    n_tests++; if (m_rvalid_o !== 1'b1 || m_rresp_o !== 2'b11 || s0_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL bnd_past: got v=%b r=%b s0ar=%b want 1/11/0", m_rvalid_o, m_rresp_o, s0_arvalid_o); end
    @(negedge clk_i); #1;
  endtask

  task automatic test_reset_in_r();
    m_rready_i = 0;
    @(negedge clk_i); m_arvalid_i = 1; m_araddr_i = 32'h8000_0010; #1;
    @(negedge clk_i); m_arvalid_i = 0; #1;
    @(negedge clk_i); #1;
    n_tests++; if (m_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rir_in_r: got %b want 1", m_rvalid_o); end
    @(negedge clk_i); rst_i = 1'b0; #1;
    n_tests++; if (m_rvalid_o !== 1'b0 || m_rdata_o !== 32'h0 || m_arready_o !== 1'b0) begin n_fail++; $display("FAIL rir_outs: got v=%b d=%h ar=%b want 0/0/0", m_rvalid_o, m_rdata_o, m_arready_o); end
    n_tests++; if (s0_rready_o !== 1'b0 || s0_araddr_o !== 32'h0) begin n_fail++; $display("FAIL rir_slave: got rr=%b a=%h want 0/0", s0_rready_o, s0_araddr_o); end
    @(negedge clk_i); rst_i = 1'b1; #1;
    n_tests++; if (m_arready_o !== 1'b0) begin n_fail++; $display("FAIL rir_arready_early: got %b want 0", m_arready_o); end
    m_rready_i = 1;
    @(negedge clk_i); #1;
    n_tests++; if (m_arready_o !== 1'b1 || m_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rir_after: got ar=%b rv=%b want 1/0", m_arready_o, m_rvalid_o); end
  endtask

  initial begin
    test_reset();
    test_read_s0();
    test_write_s1_delayed();
    test_decerr_read();
    test_rd_wr_priority();
    test_boundary();
    test_reset_in_r();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_xbar.md
AXI_LITE_XBAR -- requirements
Module: axi_lite_xbar

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-004 SHALL have parameters SRAM_BASE, default 32'h8000_0000, and SRAM_SIZE, default 32'h0800_0000, for the slave-0 window.
REQ-005 SHALL have parameters DEV_BASE, default 32'ha000_0000, and DEV_SIZE, default 32'h0001_0000, for the slave-1 window.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have master-side ports m_araddr_i/m_awaddr_i (in, ADDR_WIDTH), m_wdata_i (in, DATA_WIDTH), m_wstrb_i (in, STRB_WIDTH), and m_arvalid_i/m_awvalid_i/m_wvalid_i/m_rready_i/m_bready_i (in, 1).
REQ-009 SHALL have master-side ports m_arready_o/m_awready_o/m_wready_o/m_rvalid_o/m_bvalid_o (out, 1), m_rdata_o (out, DATA_WIDTH), and m_rresp_o/m_bresp_o (out, 2).
REQ-010 SHALL have, for each slave x in {s0 (SRAM), s1 (DEV)}, ports x_araddr_o/x_awaddr_o (out, ADDR_WIDTH), x_wdata_o (out, DATA_WIDTH), x_wstrb_o (out, STRB_WIDTH), x_arvalid_o/x_awvalid_o/x_wvalid_o/x_rready_o/x_bready_o (out, 1), x_arready_i/x_awready_i/x_wready_i/x_rvalid_i/x_bvalid_i (in, 1), x_rdata_i (in, DATA_WIDTH), and x_rresp_i/x_bresp_i (in, 2).

Function
REQ-011 SHALL allow exactly one outstanding transaction; states IDLE, AR, R, AW, B, ERR_R, ERR_B.
REQ-012 SHALL decode a slave hit as BASE <= addr < BASE+SIZE, computed in ADDR_WIDTH+1 bits so the comparison never wraps; if both windows match, s0 wins.
REQ-013 In IDLE with m_arvalid_i=1, SHALL assert m_arready_o, latch the address and slave select, and go to AR on a hit or to ERR_R on a miss.
REQ-014 In IDLE with m_arvalid_i=0 and m_awvalid_i=m_wvalid_i=1, SHALL assert m_awready_o and m_wready_o in the same cycle, latch address, data and strobe, and go to AW on a hit or to ERR_B on a miss.
REQ-015 SHALL give reads priority over writes when both are presented in the same IDLE cycle; a write with only one of AW/W valid SHALL NOT be accepted.
REQ-016 In AR, SHALL drive the selected x_arvalid_o=1 with the latched address, and go to R on x_arready_i.
REQ-017 In R, SHALL pass x_rvalid_i/x_rdata_i/x_rresp_i to the master and m_rready_i to x_rready_o, and go to IDLE on the rvalid&rready handshake.
REQ-018 In AW, SHALL drive x_awvalid_o and x_wvalid_o, each deasserting after its own handshake (tracked by aw_done/w_done flags), and go to B once both are done, including when both complete in the same cycle.
REQ-019 In B, SHALL pass bvalid/bresp to the master and m_bready_i to x_bready_o, and go to IDLE on handshake.
REQ-020 In ERR_R, SHALL drive m_rvalid_o=1, m_rdata_o=0, m_rresp_o=2'b11 (DECERR) without touching either slave, and go to IDLE on m_rready_i.
REQ-021 In ERR_B, SHALL drive m_bvalid_o=1 and m_bresp_o=2'b11, and go to IDLE on m_bready_i.
REQ-022 SHALL hold all valid/ready outputs of the unselected slave at 0 in every state, and SHALL drive slave address/data/strobe outputs from the latched registers.
REQ-023 SHALL keep master rvalid/bvalid at 0 outside R/ERR_R and B/ERR_B, with m_rdata_o/m_rresp_o/m_bresp_o at 0 when their valid is low.
REQ-024 SHALL give minimum read latency of 3 cycles from m_arvalid_i acceptance to m_rvalid_o with a zero-wait slave.

Reset
REQ-025 While rst_i=0, SHALL force state IDLE, aw_done=w_done=0, latched registers 0, and all outputs 0.
REQ-026 SHALL gate m_arready_o/m_awready_o/m_wready_o by a registered init flag that is cleared by reset and set on the first clk_i edge after release, so no handshake can occur during reset or on that edge.
REQ-027 SHALL abandon any transaction interrupted by reset mid-operation, with no response issued afterwards.

Verification
REQ-028 Read of 0x8000_0010, s0 returns 0xDEADBEEF with rresp 0 -> m_rdata_o=0xDEADBEEF and m_rresp_o=0; all s1 valids stay 0.
REQ-029 Write of 0xA000_03F8 with data 0x41 and strb 4'b0001, s1 awready delayed 2 cycles and wready immediate -> s1_wvalid_o drops after 1 cycle, B is reached only after awready, and m_bresp_o=0.
REQ-030 Read of 0x0000_1000 -> m_rresp_o=2'b11 and m_rdata_o=0, with no slave arvalid pulse.
REQ-031 Read of 0x8000_0000 and write of 0xA000_0000 presented in the same cycle -> read completes first, and the write is accepted on the next IDLE cycle.
REQ-032 Boundary addresses 0x87FF_FFFC and 0x8800_0000 -> s0 hit and DECERR respectively.
REQ-033 rst_i asserted while in R -> all outputs 0 immediately, and after release m_arready_o stays 0 for one cycle then rises to 1.
